// File: rtl/lcd_pkg.sv
// Shared constants and state type for the LCD frame feeder.
package lcd_pkg;

    localparam logic [7:0] LCD_CMD_CASET = 8'h2A;
    localparam logic [7:0] LCD_CMD_RASET = 8'h2B;
    localparam logic [7:0] LCD_CMD_RAMWR = 8'h2C;

    localparam int unsigned LCD_HDR_LEN   = 11;
    localparam int unsigned LCD_HDR_IDX_W = 4;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_WAIT_FM = 3'd1,
        ST_HDR     = 3'd2,
        ST_PIX_HI  = 3'd3,
        ST_PIX_LO  = 3'd4,
        ST_DONE    = 3'd5
    } lcd_state_e;

endpackage

// File: rtl/lcd_frame_feeder.sv
// Emits the CASET/RASET/RAMWR window header, then streams RGB565 pixels MSB-first to the LCD PHY.
// Optional LCD_FEEDER_FMARK_SYNC_EN: hold each frame until the PHY frame-mark strobe.
module lcd_frame_feeder
    import lcd_pkg::*;
#(
    parameter int unsigned WIDTH  = 320,
    parameter int unsigned HEIGHT = 240
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        frame_start,
    output logic        busy,
    output logic        frame_done,
    input  logic [15:0] pix_data,
    input  logic        pix_valid,
    output logic        pix_ready,
    output logic [7:0]  phy_data,
    output logic        phy_rs,
    output logic        phy_valid,
    input  logic        phy_ready,
    input  logic        phy_fmark_stb
);

    localparam longint unsigned NPIX  = 64'(WIDTH) * 64'(HEIGHT);
    localparam int unsigned     CNT_W = (NPIX > 64'd1) ? $clog2(NPIX) : 1;
    localparam logic [CNT_W-1:0] LAST_PIX = CNT_W'(NPIX - 64'd1);
    localparam logic [15:0] W_M1 = 16'(WIDTH - 1);
    localparam logic [15:0] H_M1 = 16'(HEIGHT - 1);
    localparam logic [LCD_HDR_IDX_W-1:0] HDR_LAST = LCD_HDR_IDX_W'(LCD_HDR_LEN - 1);

    lcd_state_e state_q, state_d;

    logic [LCD_HDR_IDX_W-1:0] hdr_idx_q, hdr_idx_d;
    logic [CNT_W-1:0]         pix_cnt_q, pix_cnt_d;
    logic [7:0]               lo_byte_q, lo_byte_d;
    logic [7:0]               phy_data_q, phy_data_d;
    logic                     phy_rs_q, phy_rs_d;
    logic                     phy_valid_q, phy_valid_d;
    logic                     busy_q, busy_d;
    logic                     done_q, done_d;

    logic       slot_free_c;
    logic [7:0] hdr_byte_c;
    logic       hdr_rs_c;

    // The output register can take a new byte when empty or being drained this cycle.
    assign slot_free_c = ~phy_valid_q | phy_ready;

    // Window-setup header byte mux; command bytes go out with rs=0.
    always_comb begin
        hdr_byte_c = 8'h00;
        hdr_rs_c   = 1'b1;
        case (hdr_idx_q)
            4'd0: begin hdr_byte_c = LCD_CMD_CASET; hdr_rs_c = 1'b0; end
            4'd3: hdr_byte_c = W_M1[15:8];
            4'd4: hdr_byte_c = W_M1[7:0];
            4'd5: begin hdr_byte_c = LCD_CMD_RASET; hdr_rs_c = 1'b0; end
            4'd8: hdr_byte_c = H_M1[15:8];
            4'd9: hdr_byte_c = H_M1[7:0];
            4'd10: begin hdr_byte_c = LCD_CMD_RAMWR; hdr_rs_c = 1'b0; end
            default: begin hdr_byte_c = 8'h00; hdr_rs_c = 1'b1; end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (frame_start) begin
`ifdef LCD_FEEDER_FMARK_SYNC_EN
                    state_d = ST_WAIT_FM;
`else
                    state_d = ST_HDR;
`endif
                end
            end
            ST_WAIT_FM: begin
                if (phy_fmark_stb) state_d = ST_HDR;
            end
            ST_HDR: begin
                if (slot_free_c && (hdr_idx_q == HDR_LAST)) state_d = ST_PIX_HI;
            end
            ST_PIX_HI: begin
                if (slot_free_c && pix_valid) state_d = ST_PIX_LO;
            end
            ST_PIX_LO: begin
                if (slot_free_c) state_d = (pix_cnt_q == LAST_PIX) ? ST_DONE : ST_PIX_HI;
            end
            ST_DONE: begin
                if (slot_free_c) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Datapath and handshake outputs; an idle free slot drops phy_valid.
    always_comb begin
        hdr_idx_d   = hdr_idx_q;
        pix_cnt_d   = pix_cnt_q;
        lo_byte_d   = lo_byte_q;
        phy_data_d  = phy_data_q;
        phy_rs_d    = phy_rs_q;
        phy_valid_d = phy_valid_q;
        busy_d      = busy_q;
        done_d      = 1'b0;
        pix_ready   = 1'b0;

        if (slot_free_c) phy_valid_d = 1'b0;

        case (state_q)
            ST_IDLE: begin
                hdr_idx_d = '0;
                pix_cnt_d = '0;
                if (frame_start) busy_d = 1'b1;
            end
            ST_HDR: begin
                if (slot_free_c) begin
                    phy_data_d  = hdr_byte_c;
                    phy_rs_d    = hdr_rs_c;
                    phy_valid_d = 1'b1;
                    hdr_idx_d   = hdr_idx_q + LCD_HDR_IDX_W'(1);
                end
            end
            ST_PIX_HI: begin
                pix_ready = slot_free_c;
                if (slot_free_c && pix_valid) begin
                    phy_data_d  = pix_data[15:8];
                    phy_rs_d    = 1'b1;
                    phy_valid_d = 1'b1;
                    lo_byte_d   = pix_data[7:0];
                end
            end
            ST_PIX_LO: begin
                if (slot_free_c) begin
                    phy_data_d  = lo_byte_q;
                    phy_rs_d    = 1'b1;
                    phy_valid_d = 1'b1;
                    pix_cnt_d   = pix_cnt_q + CNT_W'(1);
                end
            end
            ST_DONE: begin
                if (slot_free_c) begin
                    done_d = 1'b1;
                    busy_d = 1'b0;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hdr_idx_q   <= '0;
            pix_cnt_q   <= '0;
            lo_byte_q   <= 8'h00;
            phy_data_q  <= 8'h00;
            phy_rs_q    <= 1'b0;
            phy_valid_q <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            hdr_idx_q   <= hdr_idx_d;
            pix_cnt_q   <= pix_cnt_d;
            lo_byte_q   <= lo_byte_d;
            phy_data_q  <= phy_data_d;
            phy_rs_q    <= phy_rs_d;
            phy_valid_q <= phy_valid_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
        end
    end

    assign phy_data   = phy_data_q;
    assign phy_rs     = phy_rs_q;
    assign phy_valid  = phy_valid_q;
    assign busy       = busy_q;
    assign frame_done = done_q;

endmodule

// File: tb/tb_lcd_frame_feeder.sv
// Scoreboard bench for lcd_frame_feeder: a 4x2 and a 1x1 instance share stimulus, selected per frame.
module tb_lcd_frame_feeder;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n, sel, frame_start, pix_valid, phy_ready, fmark;
    logic [15:0] pix_data, pix_base;

    logic       a_fs, a_busy, a_done, a_pr, a_rs, a_valid;
    logic [7:0] a_data;
    logic       b_fs, b_busy, b_done, b_pr, b_rs, b_valid;
    logic [7:0] b_data;

    assign a_fs = frame_start & ~sel;
    assign b_fs = frame_start & sel;

    lcd_frame_feeder #(.WIDTH(4), .HEIGHT(2)) dut_a (
        .clk(clk), .rst_n(rst_n), .frame_start(a_fs), .busy(a_busy), .frame_done(a_done),
        .pix_data(pix_data), .pix_valid(pix_valid), .pix_ready(a_pr),
        .phy_data(a_data), .phy_rs(a_rs), .phy_valid(a_valid), .phy_ready(phy_ready),
        .phy_fmark_stb(fmark)
    );

    lcd_frame_feeder #(.WIDTH(1), .HEIGHT(1)) dut_b (
        .clk(clk), .rst_n(rst_n), .frame_start(b_fs), .busy(b_busy), .frame_done(b_done),
        .pix_data(pix_data), .pix_valid(pix_valid), .pix_ready(b_pr),
        .phy_data(b_data), .phy_rs(b_rs), .phy_valid(b_valid), .phy_ready(phy_ready),
        .phy_fmark_stb(fmark)
    );

    logic       m_busy, m_done, m_pr, m_rs, m_valid;
    logic [7:0] m_data;
    assign m_busy  = sel ? b_busy  : a_busy;
    assign m_done  = sel ? b_done  : a_done;
    assign m_pr    = sel ? b_pr    : a_pr;
    assign m_rs    = sel ? b_rs    : a_rs;
    assign m_valid = sel ? b_valid : a_valid;
    assign m_data  = sel ? b_data  : a_data;

    logic [8:0] exp_q[$];
    int n_checks = 0;
    int n_fail = 0;
    int cyc = 0;
    int bytes_seen = 0;
    int done_cnt = 0;
    int first_hs_cyc = 0;
    int last_hs_cyc = 0;
    int pix_n = 0;
    int rmode = 0;
    int vmode = 0;

    assign pix_data = pix_base + 16'(pix_n);

    always @(posedge clk) cyc++;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Reference model: header from the window size, then each pixel as hi/lo data bytes.
    function automatic void push_frame(input int w, input int h, input logic [15:0] base);
        logic [15:0] wm, hm, p;
        wm = 16'(w - 1);
        hm = 16'(h - 1);
        exp_q.push_back({1'b0, 8'h2A});
        exp_q.push_back({1'b1, 8'h00});
        exp_q.push_back({1'b1, 8'h00});
        exp_q.push_back({1'b1, wm[15:8]});
        exp_q.push_back({1'b1, wm[7:0]});
        exp_q.push_back({1'b0, 8'h2B});
        exp_q.push_back({1'b1, 8'h00});
        exp_q.push_back({1'b1, 8'h00});
        exp_q.push_back({1'b1, hm[15:8]});
        exp_q.push_back({1'b1, hm[7:0]});
        exp_q.push_back({1'b0, 8'h2C});
        for (int k = 0; k < w * h; k++) begin
            p = base + 16'(k);
            exp_q.push_back({1'b1, p[15:8]});
            exp_q.push_back({1'b1, p[7:0]});
        end
    endfunction

    // Source and PHY-side driver: advance the pixel after each accepted handshake.
    initial begin
        logic hs;
        phy_ready = 1'b1;
        pix_valid = 1'b0;
        forever begin
            @(negedge clk);
            hs = pix_valid & m_pr & rst_n;
            @(posedge clk);
            #1;
            if (hs) pix_n++;
            case (rmode)
                0: phy_ready = 1'b1;
                1: phy_ready = ~phy_ready;
                default: phy_ready = 1'($urandom % 2);
            endcase
            pix_valid = (vmode == 0) ? 1'b1 : ($urandom % 3 != 0);
        end
    end

    // Monitor: pop and compare on every PHY handshake; check hold and done timing.
    initial begin
        logic       prev_stall;
        logic [8:0] prev_byte, e;
        prev_stall = 1'b0;
        prev_byte  = 9'h0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                prev_stall = 1'b0;
            end else begin
                if (prev_stall) begin
                    chk("hold_valid", 32'(m_valid), 32'd1);
                    chk("hold_byte", 32'({m_rs, m_data}), 32'(prev_byte));
                end
                if (m_valid && phy_ready) begin
                    chk("busy_while_streaming", 32'(m_busy), 32'd1);
                    if (exp_q.size() == 0) begin
                        n_checks++;
                        n_fail++;
                        $display("FAIL unexpected_byte: got %0h expected none", {m_rs, m_data});
                    end else begin
                        e = exp_q.pop_front();
                        chk("phy_byte", 32'({m_rs, m_data}), 32'(e));
                    end
                    if (bytes_seen == 0) first_hs_cyc = cyc;
                    bytes_seen++;
                    last_hs_cyc = cyc;
                end
                if (m_done) begin
                    done_cnt++;
                    chk("done_after_last_accept", 32'(cyc - last_hs_cyc), 32'd1);
                    chk("done_queue_empty", 32'(exp_q.size()), 32'd0);
                    chk("busy_low_at_done", 32'(m_busy), 32'd0);
                end
                prev_stall = m_valid & ~phy_ready;
                prev_byte  = {m_rs, m_data};
            end
        end
    end

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_a_valid"}, 32'(a_valid), 32'd0);
        chk({tag, "_a_data"}, 32'({a_rs, a_data}), 32'd0);
        chk({tag, "_a_busy_done_pr"}, 32'({a_busy, a_done, a_pr}), 32'd0);
        chk({tag, "_b_outs"}, 32'({b_valid, b_rs, b_data, b_busy, b_done, b_pr}), 32'd0);
    endtask

    task automatic start_frame(input bit use_b, input int rm, input int vm, output int done0);
        int w, h;
        @(posedge clk);
        #2;
        sel   = use_b;
        rmode = rm;
        vmode = vm;
        w = use_b ? 1 : 4;
        h = use_b ? 1 : 2;
        push_frame(w, h, pix_base + 16'(pix_n));
        bytes_seen  = 0;
        done0       = done_cnt;
        frame_start = 1'b1;
`ifdef LCD_FEEDER_FMARK_SYNC_EN
        fmark = 1'b1;
`endif
        @(posedge clk);
        #2;
        frame_start = 1'b0;
`ifdef LCD_FEEDER_FMARK_SYNC_EN
        fmark = 1'b0;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            chk("fm_wait_no_valid", 32'(m_valid), 32'd0);
            chk("fm_wait_busy", 32'(m_busy), 32'd1);
        end
        @(posedge clk);
        #2;
        fmark = 1'b1;
        @(posedge clk);
        #2;
        fmark = 1'b0;
        @(negedge clk);
        chk("fm_first_byte_latency", 32'(m_valid), 32'd0);
        @(negedge clk);
        chk("fm_first_byte", 32'({m_valid, m_rs, m_data}), 32'({1'b1, 1'b0, 8'h2A}));
`endif
    endtask

    task automatic run_frame(input bit use_b, input int rm, input int vm, input bit glitch);
        int  done0, nbytes;
        bit  g1, g2;
        g1 = 1'b0;
        g2 = 1'b0;
        nbytes = use_b ? 13 : 27;
        start_frame(use_b, rm, vm, done0);
        for (int i = 0; i < 3000 && done_cnt == done0; i++) begin
            @(posedge clk);
            #2;
            if (glitch && ((!g1 && bytes_seen >= 3) || (!g2 && bytes_seen >= 14))) begin
                if (bytes_seen >= 14) g2 = 1'b1;
                g1 = 1'b1;
                frame_start = 1'b1;
                @(posedge clk);
                #2;
                frame_start = 1'b0;
            end
        end
        chk("frame_completed", 32'(done_cnt - done0), 32'd1);
        chk("byte_count", 32'(bytes_seen), 32'(nbytes));
        if (rm == 0 && vm == 0)
            chk("full_rate_span", 32'(last_hs_cyc - first_hs_cyc), 32'(nbytes - 1));
        repeat (6) @(posedge clk);
        @(negedge clk);
        chk("single_done", 32'(done_cnt - done0), 32'd1);
        chk("idle_after_frame", 32'({m_busy, m_valid}), 32'd0);
        chk("queue_drained", 32'(exp_q.size()), 32'd0);
        exp_q.delete();
    endtask

    initial begin
        int done0;
        rst_n       = 1'b0;
        sel         = 1'b0;
        frame_start = 1'b0;
        fmark       = 1'b0;
        pix_base    = 16'h1234;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_reset_outputs("reset");
        rst_n = 1'b1;

        run_frame(1'b0, 0, 0, 1'b0);
        run_frame(1'b0, 1, 1, 1'b0);
        run_frame(1'b0, 0, 0, 1'b1);
        run_frame(1'b0, 1, 1, 1'b1);
        run_frame(1'b1, 0, 0, 1'b0);
        run_frame(1'b1, 2, 1, 1'b0);

        // Abort a frame with reset partway through the pixel stream.
        start_frame(1'b0, 0, 0, done0);
        for (int i = 0; i < 3000 && bytes_seen < 16; i++) @(posedge clk);
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check_reset_outputs("async_reset");
        exp_q.delete();
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (4) @(posedge clk);
        @(negedge clk);
        chk("no_done_after_abort", 32'(done_cnt - done0), 32'd0);
        run_frame(1'b0, 0, 0, 1'b0);

        for (int r = 0; r < 4; r++) begin
            pix_base = 16'($urandom);
            run_frame(1'($urandom % 2), int'($urandom % 3), int'($urandom % 2), 1'($urandom % 2));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
